// File: rtl/lfsr_rng_core_if.sv
// lfsr_rng_core bus: control strobes in, LFSR state and pulses out.
// master drives en/mode_step/step_req/load/load_val; slave drives rnd and pulses.
interface lfsr_rng_core_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             mode_step;
  logic             step_req;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] rnd;
  logic             rnd_valid;
  logic             tick;
  logic             period_done;
  logic             lockup;

  modport master (
    output en,
    output mode_step,
    output step_req,
    output load,
    output load_val,
    input  rnd,
    input  rnd_valid,
    input  tick,
    input  period_done,
    input  lockup
  );

  modport slave (
    input  en,
    input  mode_step,
    input  step_req,
    input  load,
    input  load_val,
    output rnd,
    output rnd_valid,
    output tick,
    output period_done,
    output lockup
  );
endinterface

// File: rtl/lfsr_rng_core.sv
// Fibonacci LFSR generator with tick prescaler, run/step modes and seed load.
// Ports: Clk, Resetn (async active-low), bus (lfsr_rng_core_if.slave).
module lfsr_rng_core #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'h002D),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(16'hACE1),
  parameter int               TICK_DIV = 50_000_000
) (
  input logic            Clk,
  input logic            Resetn,
  lfsr_rng_core_if.slave bus
);

  localparam int CW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TICK_DIV - 1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] start;
  logic [CW-1:0]    cnt;
  logic             step_req_d;
  logic             valid_q;
  logic             pdone_q;
  logic             lock_q;

  logic             tick_c;
  logic             step_rise;
  logic             shift_req;
  logic [WIDTH-1:0] shifted;

  logic             ld_zero;
  logic             ld_val;
  logic             sh_zero;
  logic             sh_ok;

  logic [WIDTH-1:0] nxt_state;
  logic [WIDTH-1:0] nxt_start;
  logic             nxt_valid;
  logic             nxt_pdone;
  logic             nxt_lock;

  // Prescaler wrap is only meaningful while counting.
  assign tick_c    = bus.en & (cnt == CNT_MAX);
  assign step_rise = bus.step_req & ~step_req_d;

  always_comb begin
    shift_req = 1'b0;
    if (bus.en) begin
      if (bus.mode_step) shift_req = step_rise;
      else               shift_req = tick_c;
    end
  end

  assign shifted = {^(state & TAPS), state[WIDTH-1:1]};

  // Mutually exclusive actions; load wins and drops any shift.
  assign ld_zero = bus.load & ~|bus.load_val;
  assign ld_val  = bus.load &  |bus.load_val;
  assign sh_zero = ~bus.load & shift_req & ~|state;
  assign sh_ok   = ~bus.load & shift_req &  |state;

  always_comb begin
    nxt_state = state;
    nxt_start = start;
    nxt_valid = 1'b0;
    nxt_pdone = 1'b0;
    nxt_lock  = 1'b0;
    unique case (1'b1)
      ld_zero: begin
        nxt_state = SEED;
        nxt_start = SEED;
        nxt_valid = 1'b1;
        nxt_lock  = 1'b1;
      end
      ld_val: begin
        nxt_state = bus.load_val;
        nxt_start = bus.load_val;
        nxt_valid = 1'b1;
      end
      sh_zero: begin
        nxt_state = SEED;
        nxt_valid = 1'b1;
        nxt_lock  = 1'b1;
      end
      sh_ok: begin
        nxt_state = shifted;
        nxt_valid = 1'b1;
        nxt_pdone = (shifted == start);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if (bus.en) begin
      if (cnt == CNT_MAX) cnt <= '0;
      else                cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) step_req_d <= 1'b0;
    else         step_req_d <= bus.step_req;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state   <= SEED;
      start   <= SEED;
      valid_q <= 1'b0;
      pdone_q <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      start   <= nxt_start;
      valid_q <= nxt_valid;
      pdone_q <= nxt_pdone;
      lock_q  <= nxt_lock;
    end
  end

  assign bus.rnd         = state;
  assign bus.rnd_valid   = valid_q;
  assign bus.tick        = tick_c;
  assign bus.period_done = pdone_q;
  assign bus.lockup      = lock_q;

endmodule

// File: tb/tb_lfsr_rng_core.sv
// Directed bench for lfsr_rng_core: vector table plus step/freeze/reset/period runs.
// Two instances: TICK_DIV=4 for control paths, TICK_DIV=1 for full period.
module tb_lfsr_rng_core;

  logic Clk;
  logic Resetn;

  int n_run  = 0;
  int n_fail = 0;

  lfsr_rng_core_if #(.WIDTH(16)) bus_a ();
  lfsr_rng_core_if #(.WIDTH(16)) bus_b ();

  lfsr_rng_core #(
    .WIDTH   (16),
    .TAPS    (16'h002D),
    .SEED    (16'hACE1),
    .TICK_DIV(4)
  ) u_dut (
    .Clk   (Clk),
    .Resetn(Resetn),
    .bus   (bus_a.slave)
  );

  lfsr_rng_core #(
    .WIDTH   (16),
    .TAPS    (16'h002D),
    .SEED    (16'hACE1),
    .TICK_DIV(1)
  ) u_fast (
    .Clk   (Clk),
    .Resetn(Resetn),
    .bus   (bus_b.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        en;
    logic        ms;
    logic        sr;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] rnd;
    logic        v;
    logic        t;
    logic        pd;
    logic        lk;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive_a(input logic en, input logic ms,
                         input logic sr, input logic ld,
                         input logic [15:0] lv);
    bus_a.en        = en;
    bus_a.mode_step = ms;
    bus_a.step_req  = sr;
    bus_a.load      = ld;
    bus_a.load_val  = lv;
  endtask

  initial begin
    int nv;
    int nt;
    int tick_at;
    logic bad;
    bit seen;

    // en ms sr ld lv      rnd      v  t  pd lk
    vecs[0]  = '{0,0,0,0,16'h0000, 16'hACE1,0,0,0,0};
    vecs[1]  = '{1,0,0,0,16'h0000, 16'hACE1,0,0,0,0};
    vecs[2]  = '{1,0,0,0,16'h0000, 16'hACE1,0,0,0,0};
    vecs[3]  = '{1,0,0,0,16'h0000, 16'hACE1,0,0,0,0};
    vecs[4]  = '{1,0,0,0,16'h0000, 16'hACE1,0,1,0,0};
    vecs[5]  = '{1,0,0,0,16'h0000, 16'h5670,1,0,0,0};
    vecs[6]  = '{1,0,0,0,16'h0000, 16'h5670,0,0,0,0};
    vecs[7]  = '{1,0,0,0,16'h0000, 16'h5670,0,0,0,0};
    vecs[8]  = '{1,0,0,0,16'h0000, 16'h5670,0,1,0,0};
    vecs[9]  = '{1,0,0,0,16'h0000, 16'hAB38,1,0,0,0};
    vecs[10] = '{1,0,0,0,16'h0000, 16'hAB38,0,0,0,0};
    vecs[11] = '{1,0,0,0,16'h0000, 16'hAB38,0,0,0,0};
    vecs[12] = '{1,0,0,1,16'h1234, 16'hAB38,0,1,0,0};
    vecs[13] = '{1,0,0,0,16'h0000, 16'h1234,1,0,0,0};
    vecs[14] = '{1,0,0,0,16'h0000, 16'h1234,0,0,0,0};
    vecs[15] = '{1,0,0,0,16'h0000, 16'h1234,0,0,0,0};
    vecs[16] = '{1,0,0,0,16'h0000, 16'h1234,0,1,0,0};
    vecs[17] = '{1,0,0,0,16'h0000, 16'h091A,1,0,0,0};
    vecs[18] = '{1,0,0,1,16'h0000, 16'h091A,0,0,0,0};
    vecs[19] = '{1,0,0,0,16'h0000, 16'hACE1,1,0,0,1};
    vecs[20] = '{1,0,0,0,16'h0000, 16'hACE1,0,1,0,0};
    vecs[21] = '{1,0,0,0,16'h0000, 16'h5670,1,0,0,0};

    Resetn = 1'b0;
    drive_a(0, 0, 0, 0, 16'h0);
    bus_b.en        = 1'b0;
    bus_b.mode_step = 1'b0;
    bus_b.step_req  = 1'b0;
    bus_b.load      = 1'b0;
    bus_b.load_val  = 16'h0;
    repeat (2) @(negedge Clk);
    Resetn = 1'b1;

    // Table: run mode, load on tick, zero load.
    for (int i = 0; i < 22; i++) begin
      @(negedge Clk);
      drive_a(vecs[i].en, vecs[i].ms, vecs[i].sr,
              vecs[i].ld, vecs[i].lv);
      #1;
      chk($sformatf("v%0d_rnd", i), 32'(bus_a.rnd), 32'(vecs[i].rnd));
      chk($sformatf("v%0d_valid", i), 32'(bus_a.rnd_valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_tick", i), 32'(bus_a.tick), 32'(vecs[i].t));
      chk($sformatf("v%0d_pdone", i), 32'(bus_a.period_done), 32'(vecs[i].pd));
      chk($sformatf("v%0d_lockup", i), 32'(bus_a.lockup), 32'(vecs[i].lk));
    end

    // Freeze 20 cycles with count at 1.
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      drive_a(0, 0, 0, 0, 16'h0);
      #1;
      if (bus_a.rnd !== 16'h5670 || bus_a.rnd_valid !== 1'b0 ||
          bus_a.tick !== 1'b0 || bus_a.period_done !== 1'b0 ||
          bus_a.lockup !== 1'b0)
        bad = 1'b1;
    end
    chk("freeze_quiet", 32'(bad), 32'd0);

    tick_at = -1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      drive_a(1, 0, 0, 0, 16'h0);
      #1;
      if (bus_a.tick === 1'b1 && tick_at < 0) tick_at = i;
    end
    chk("resume_tick_at", 32'(tick_at), 32'd2);
    @(negedge Clk);
    drive_a(0, 0, 0, 0, 16'h0);
    #1;
    chk("resume_rnd", 32'(bus_a.rnd), 32'hAB38);
    chk("resume_valid", 32'(bus_a.rnd_valid), 32'd1);

    // Asynchronous reset away from any clock edge.
    #2;
    Resetn = 1'b0;
    #1;
    chk("areset_rnd", 32'(bus_a.rnd), 32'hACE1);
    chk("areset_valid", 32'(bus_a.rnd_valid), 32'd0);
    @(negedge Clk);
    Resetn = 1'b1;

    // Step mode: long high level gives one shift.
    nv = 0;
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      drive_a(1, 1, (i < 10), 0, 16'h0);
      #1;
      if (bus_a.rnd_valid === 1'b1) nv++;
      if (bus_a.tick === 1'b1) nt++;
    end
    chk("step_hold_shifts", 32'(nv), 32'd1);
    chk("step_hold_ticks", 32'(nt), 32'd3);
    chk("step_hold_rnd", 32'(bus_a.rnd), 32'h5670);

    nv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      drive_a(1, 1, (i == 0), 0, 16'h0);
      #1;
      if (bus_a.rnd_valid === 1'b1) nv++;
    end
    chk("step_again_shifts", 32'(nv), 32'd1);
    chk("step_again_rnd", 32'(bus_a.rnd), 32'hAB38);

    // Full period on the TICK_DIV=1 instance.
    @(negedge Clk);
    drive_a(0, 0, 0, 0, 16'h0);
    nv = 0;
    seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge Clk);
      bus_b.en = 1'b1;
      #1;
      if (bus_b.rnd_valid === 1'b1) nv++;
      if (bus_b.period_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("period_seen", 32'(seen), 32'd1);
    chk("period_len", 32'(nv), 32'd65535);
    chk("period_rnd", 32'(bus_b.rnd), 32'hACE1);
    bus_b.en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
